// File: rtl/load_buffer_pkg.sv
// Shared constants, types and helpers for the load buffer and its extension unit.
package load_buffer_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int ROB_WIDTH         = 4;
    localparam int INST_TYPE_WIDTH   = 3;

    localparam logic [INST_TYPE_WIDTH-1:0] INST_LB  = 3'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_LH  = 3'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_LW  = 3'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_LBU = 3'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_LHU = 3'd4;

    localparam logic [1:0] MEM_LEN_B  = 2'd0;
    localparam logic [1:0] MEM_LEN_H  = 2'd1;
    localparam logic [1:0] MEM_LEN_W  = 2'd2;
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lb_state_t;

    // Access width requested from the memory controller for a load type.
    function automatic logic [1:0] mem_len(input logic [INST_TYPE_WIDTH-1:0] inst_type);
        case (inst_type)
            INST_LB, INST_LBU: mem_len = MEM_LEN_B;
            INST_LH, INST_LHU: mem_len = MEM_LEN_H;
            default:           mem_len = MEM_LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/load_buffer_extend.sv
// Combinational sign/zero extension of LSB-aligned load data; also usable by store forwarding.
module load_extend
    import load_buffer_pkg::*;
(
    input  logic [INST_TYPE_WIDTH-1:0] inst_type,
    input  logic [31:0]                raw,
    output logic [31:0]                value
);

    // Select extension by load type; words pass straight through.
    always_comb begin
        value = raw;
        case (inst_type)
            INST_LB:  value = {{24{raw[7]}}, raw[7:0]};
            INST_LBU: value = {24'd0, raw[7:0]};
            INST_LH:  value = {{16{raw[15]}}, raw[15:0]};
            INST_LHU: value = {16'd0, raw[15:0]};
            default:  value = raw;
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: queues issued loads, sends them one at a time to the
// memory controller and broadcasts the extended result on the CDB.
//
// state    | meaning
// ST_IDLE  | no read outstanding; head may issue when ordering allows
// ST_WAIT  | read for head outstanding; result goes to the CDB
// ST_DRAIN | read outstanding for a flushed load; result is discarded
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PTR_W    = 3,
    parameter int IO_GUARD = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       addressUnit_en_in,
    input  logic [31:0]                addressUnit_addr_in,
    input  logic [ROB_WIDTH-1:0]       addressUnit_dest_in,
    input  logic [INST_TYPE_WIDTH-1:0] addressUnit_inst_type_in,
    output logic                       lsqueue_rdy_out,
    input  logic                       rob_flush_in,
    input  logic [ROB_WIDTH-1:0]       rob_head_in,
    input  logic                       rob_store_pending_in,
    output logic                       memctrl_en_out,
    output logic [31:0]                memctrl_addr_out,
    output logic [1:0]                 memctrl_len_out,
    input  logic                       memctrl_done_in,
    input  logic [31:0]                memctrl_data_in,
    output logic                       cdb_en_out,
    output logic [ROB_WIDTH-1:0]       cdb_dest_out,
    output logic [31:0]                cdb_value_out
);

    // Two slots of headroom cover loads already in the LSQueue -> address unit pipe.
    localparam logic [PTR_W:0]   CNT_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_RDY_MAX = (PTR_W+1)'(DEPTH-3);
    localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    logic [31:0]                addr_q [DEPTH];
    logic [ROB_WIDTH-1:0]       dest_q [DEPTH];
    logic [INST_TYPE_WIDTH-1:0] type_q [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    lb_state_t        state, state_nxt;

    logic full, at_rob_head, is_io, issue_ok;
    logic do_enq, do_pop, do_issue;
    logic [31:0] ext_value;

    load_extend u_extend (
        .inst_type (type_q[head]),
        .raw       (memctrl_data_in),
        .value     (ext_value)
    );

    assign lsqueue_rdy_out = (count <= CNT_RDY_MAX);

    // Ordering checks for the head entry and enqueue acceptance.
    always_comb begin
        full        = (count == CNT_FULL);
        at_rob_head = (dest_q[head] == rob_head_in);
        is_io       = (addr_q[head][17:16] == IO_ADDR_HI);
        issue_ok    = (count != '0)
                    && (at_rob_head || !rob_store_pending_in)
                    && (!((IO_GUARD != 0) && is_io) || at_rob_head);
        do_enq      = addressUnit_en_in && !rob_flush_in && !full;
    end

    // Next-state and issue/pop decisions.
    always_comb begin
        state_nxt = state;
        do_issue  = 1'b0;
        do_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rob_flush_in && issue_ok) begin
                    do_issue  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A read that completes in the flush cycle is simply dropped.
                if (rob_flush_in) begin
                    state_nxt = memctrl_done_in ? ST_IDLE : ST_DRAIN;
                end else if (memctrl_done_in) begin
                    do_pop    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (memctrl_done_in) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, pointers, occupancy and registered pulse/data outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= ST_IDLE;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            memctrl_en_out   <= 1'b0;
            memctrl_addr_out <= '0;
            memctrl_len_out  <= '0;
            cdb_en_out       <= 1'b0;
            cdb_dest_out     <= '0;
            cdb_value_out    <= '0;
        end else if (rdy_in) begin
            state          <= state_nxt;
            memctrl_en_out <= do_issue;
            cdb_en_out     <= do_pop;
            if (do_issue) begin
                memctrl_addr_out <= addr_q[head];
                memctrl_len_out  <= mem_len(type_q[head]);
            end
            if (do_pop) begin
                cdb_dest_out  <= dest_q[head];
                cdb_value_out <= ext_value;
            end
            if (rob_flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_enq) tail <= tail + PTR_ONE;
                if (do_pop) head <= head + PTR_ONE;
                case ({do_enq, do_pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; contents are qualified by head/tail/count so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (rdy_in && do_enq) begin
            addr_q[tail] <= addressUnit_addr_in;
            dest_q[tail] <= addressUnit_dest_in;
            type_q[tail] <= addressUnit_inst_type_in;
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && addressUnit_en_in && !rob_flush_in && full));

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: vector table plus directed corner sequences,
// with a CDB scoreboard fed when each memory request is observed.
module tb_load_buffer;
    import load_buffer_pkg::*;

    logic                       clk_in = 1'b0;
    logic                       rst_in;
    logic                       rdy_in;
    logic                       addressUnit_en_in;
    logic [31:0]                addressUnit_addr_in;
    logic [ROB_WIDTH-1:0]       addressUnit_dest_in;
    logic [INST_TYPE_WIDTH-1:0] addressUnit_inst_type_in;
    logic                       lsqueue_rdy_out;
    logic                       rob_flush_in;
    logic [ROB_WIDTH-1:0]       rob_head_in;
    logic                       rob_store_pending_in;
    logic                       memctrl_en_out;
    logic [31:0]                memctrl_addr_out;
    logic [1:0]                 memctrl_len_out;
    logic                       memctrl_done_in;
    logic [31:0]                memctrl_data_in;
    logic                       cdb_en_out;
    logic [ROB_WIDTH-1:0]       cdb_dest_out;
    logic [31:0]                cdb_value_out;

    always #5 clk_in = ~clk_in;

    load_buffer #(.DEPTH(8), .PTR_W(3), .IO_GUARD(1)) dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .rdy_in                   (rdy_in),
        .addressUnit_en_in        (addressUnit_en_in),
        .addressUnit_addr_in      (addressUnit_addr_in),
        .addressUnit_dest_in      (addressUnit_dest_in),
        .addressUnit_inst_type_in (addressUnit_inst_type_in),
        .lsqueue_rdy_out          (lsqueue_rdy_out),
        .rob_flush_in             (rob_flush_in),
        .rob_head_in              (rob_head_in),
        .rob_store_pending_in     (rob_store_pending_in),
        .memctrl_en_out           (memctrl_en_out),
        .memctrl_addr_out         (memctrl_addr_out),
        .memctrl_len_out          (memctrl_len_out),
        .memctrl_done_in          (memctrl_done_in),
        .memctrl_data_in          (memctrl_data_in),
        .cdb_en_out               (cdb_en_out),
        .cdb_dest_out             (cdb_dest_out),
        .cdb_value_out            (cdb_value_out)
    );

    typedef struct {
        logic [31:0]                addr;
        logic [ROB_WIDTH-1:0]       dest;
        logic [INST_TYPE_WIDTH-1:0] typ;
    } load_t;

    typedef struct {
        logic [ROB_WIDTH-1:0] dest;
        logic [31:0]          value;
    } cdb_t;

    typedef struct {
        logic [INST_TYPE_WIDTH-1:0] typ;
        logic [31:0]                addr;
        logic [ROB_WIDTH-1:0]       dest;
        logic [31:0]                data;
        int                         delay;
        logic [1:0]                 len;
        logic [31:0]                value;
    } vec_t;

    load_t mq[$];
    cdb_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic enq(input logic [INST_TYPE_WIDTH-1:0] t, input logic [31:0] a,
                       input logic [ROB_WIDTH-1:0] d);
        load_t ld;
        addressUnit_en_in        = 1'b1;
        addressUnit_addr_in      = a;
        addressUnit_dest_in      = d;
        addressUnit_inst_type_in = t;
        ld.addr = a; ld.dest = d; ld.typ = t;
        mq.push_back(ld);
        tick();
        addressUnit_en_in = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (memctrl_en_out) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: no memctrl request within 40 cycles");
        end
    endtask

    task automatic serve(input logic [31:0] data, input int delay, input logic [1:0] exp_len,
                         input logic [31:0] exp_val, input string tag);
        bit    ok;
        load_t ld;
        cdb_t  e;
        wait_req(ok);
        if (!ok) return;
        if (mq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: request with no load pending, addr 0x%08h", tag, memctrl_addr_out);
            return;
        end
        ld = mq.pop_front();
        check({tag, " addr"}, memctrl_addr_out, ld.addr);
        check({tag, " len"}, 32'(memctrl_len_out), 32'(exp_len));
        e.dest = ld.dest; e.value = exp_val;
        sb.push_back(e);
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i == 0) check({tag, " req pulse"}, 32'(memctrl_en_out), 32'd0);
        end
        memctrl_done_in = 1'b1;
        memctrl_data_in = data;
        tick();
        memctrl_done_in = 1'b0;
        memctrl_data_in = '0;
        check({tag, " cdb_en"}, 32'(cdb_en_out), 32'd1);
    endtask

    task automatic reset_and_check(input string tag);
        rst_in = 1'b1;
        #1;
        check({tag, " memctrl_en"}, 32'(memctrl_en_out), 32'd0);
        check({tag, " cdb_en"}, 32'(cdb_en_out), 32'd0);
        check({tag, " lsqueue_rdy"}, 32'(lsqueue_rdy_out), 32'd1);
        check({tag, " memctrl_addr"}, memctrl_addr_out, 32'd0);
        check({tag, " cdb_value"}, cdb_value_out, 32'd0);
        tick();
        rst_in = 1'b0;
        mq.delete();
        sb.delete();
    endtask

    // CDB monitor: every pulse must match the oldest expected result.
    always @(negedge clk_in) begin
        if (cdb_en_out) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL cdb unexpected: dest %0d value 0x%08h, expected no pulse",
                         cdb_dest_out, cdb_value_out);
            end else begin
                cdb_t e;
                e = sb.pop_front();
                if (cdb_dest_out !== e.dest || cdb_value_out !== e.value) begin
                    n_fail++;
                    $display("FAIL cdb result: dest %0d value 0x%08h, expected dest %0d value 0x%08h",
                             cdb_dest_out, cdb_value_out, e.dest, e.value);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  vt[7];
        bit    ok;
        load_t ld;
        cdb_t  e;

        vt[0] = '{INST_LB,  32'h0000_0100, 4'd5,  32'h0000_00F0, 3, MEM_LEN_B, 32'hFFFF_FFF0};
        vt[1] = '{INST_LBU, 32'h0000_0100, 4'd5,  32'h0000_00F0, 3, MEM_LEN_B, 32'h0000_00F0};
        vt[2] = '{INST_LH,  32'h0000_0202, 4'd6,  32'hABCD_8001, 1, MEM_LEN_H, 32'hFFFF_8001};
        vt[3] = '{INST_LHU, 32'h0000_0202, 4'd7,  32'h0000_8001, 2, MEM_LEN_H, 32'h0000_8001};
        vt[4] = '{INST_LW,  32'h0000_0300, 4'd8,  32'hDEAD_BEEF, 0, MEM_LEN_W, 32'hDEAD_BEEF};
        vt[5] = '{INST_LB,  32'h0000_0101, 4'd9,  32'h1234_567F, 2, MEM_LEN_B, 32'h0000_007F};
        vt[6] = '{INST_LH,  32'h0000_0204, 4'd10, 32'h55AA_1234, 1, MEM_LEN_H, 32'h0000_1234};

        rst_in = 1'b1; rdy_in = 1'b1; rob_flush_in = 1'b0;
        addressUnit_en_in = 1'b0; addressUnit_addr_in = '0;
        addressUnit_dest_in = '0; addressUnit_inst_type_in = '0;
        rob_head_in = '0; rob_store_pending_in = 1'b0;
        memctrl_done_in = 1'b0; memctrl_data_in = '0;
        tick(); tick();
        reset_and_check("por");

        // Reset while a read is outstanding.
        enq(INST_LW, 32'h0000_0040, 4'd1);
        wait_req(ok);
        mq.delete();
        tick();
        reset_and_check("reset mid-wait");

        // Extension vectors.
        for (int i = 0; i < 7; i++) begin
            enq(vt[i].typ, vt[i].addr, vt[i].dest);
            serve(vt[i].data, vt[i].delay, vt[i].len, vt[i].value, $sformatf("vec%0d", i));
        end

        // Fill to full while blocked, watch back-pressure, then drain with wrap.
        rob_head_in = 4'd15; rob_store_pending_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enq(INST_LW, 32'h0000_1000 + 32'(i * 4), 4'(i));
            if (i == 4) check("rdy at count5", 32'(lsqueue_rdy_out), 32'd1);
            if (i == 5) check("rdy at count6", 32'(lsqueue_rdy_out), 32'd0);
        end
        check("rdy at full", 32'(lsqueue_rdy_out), 32'd0);
        check("blocked while full", 32'(memctrl_en_out), 32'd0);
        rob_store_pending_in = 1'b0;
        for (int i = 0; i < 8; i++)
            serve(32'h0000_A000 + 32'(i), 1, MEM_LEN_W, 32'h0000_A000 + 32'(i), $sformatf("drain%0d", i));
        tick();
        check("rdy after drain", 32'(lsqueue_rdy_out), 32'd1);
        enq(INST_LBU, 32'h0000_2000, 4'd11);
        serve(32'h0000_0081, 1, MEM_LEN_B, 32'h0000_0081, "post-wrap");

        // Flush during WAIT: result discarded; load queued in DRAIN waits for done.
        enq(INST_LW, 32'h0000_0500, 4'd3);
        wait_req(ok);
        ld = mq.pop_front();
        tick();
        rob_flush_in = 1'b1;
        tick();
        rob_flush_in = 1'b0;
        enq(INST_LW, 32'h0000_0600, 4'd6);
        check("drain no issue 1", 32'(memctrl_en_out), 32'd0);
        tick();
        check("drain no issue 2", 32'(memctrl_en_out), 32'd0);
        memctrl_done_in = 1'b1; memctrl_data_in = 32'h0000_1234;
        tick();
        memctrl_done_in = 1'b0; memctrl_data_in = '0;
        check("drain no cdb", 32'(cdb_en_out), 32'd0);
        serve(32'h0000_6666, 1, MEM_LEN_W, 32'h0000_6666, "after drain");

        // Flush coinciding with done: no CDB pulse.
        enq(INST_LW, 32'h0000_0700, 4'd4);
        wait_req(ok);
        ld = mq.pop_front();
        tick();
        rob_flush_in = 1'b1; memctrl_done_in = 1'b1; memctrl_data_in = 32'h0000_0099;
        tick();
        rob_flush_in = 1'b0; memctrl_done_in = 1'b0; memctrl_data_in = '0;
        check("flush+done no cdb", 32'(cdb_en_out), 32'd0);
        reset_and_check("post-flush reset");

        // I/O load waits for ROB head.
        rob_head_in = 4'd0;
        enq(INST_LW, 32'h0003_0000, 4'd9);
        for (int i = 0; i < 4; i++) begin
            check("io blocked", 32'(memctrl_en_out), 32'd0);
            tick();
        end
        rob_head_in = 4'd9;
        tick();
        check("io at head issues", 32'(memctrl_en_out), 32'd1);
        serve(32'h0000_1111, 1, MEM_LEN_W, 32'h0000_1111, "io");

        // Pending store blocks a normal load until it reaches ROB head.
        rob_head_in = 4'd0; rob_store_pending_in = 1'b1;
        enq(INST_LW, 32'h0000_0400, 4'd10);
        for (int i = 0; i < 4; i++) begin
            check("store-pending blocked", 32'(memctrl_en_out), 32'd0);
            tick();
        end
        rob_head_in = 4'd10;
        tick();
        check("store-pending at head issues", 32'(memctrl_en_out), 32'd1);
        serve(32'h0000_2222, 1, MEM_LEN_W, 32'h0000_2222, "pending");
        rob_store_pending_in = 1'b0;

        // rdy_in low freezes the request pulse.
        enq(INST_LW, 32'h0000_0900, 4'd2);
        wait_req(ok);
        rdy_in = 1'b0;
        tick();
        check("hold pulse 1", 32'(memctrl_en_out), 32'd1);
        tick();
        check("hold pulse 2", 32'(memctrl_en_out), 32'd1);
        rdy_in = 1'b1;
        serve(32'h0000_3333, 1, MEM_LEN_W, 32'h0000_3333, "hold");

        // Enqueue coincident with pop at count 4.
        rob_head_in = 4'd15; rob_store_pending_in = 1'b1;
        enq(INST_LH, 32'h0000_8001, 4'd0);
        enq(INST_LW, 32'h0000_8100, 4'd1);
        enq(INST_LW, 32'h0000_8104, 4'd2);
        enq(INST_LW, 32'h0000_8108, 4'd3);
        rob_head_in = 4'd0;
        wait_req(ok);
        ld = mq.pop_front();
        check("lh addr", memctrl_addr_out, 32'h0000_8001);
        check("lh len", 32'(memctrl_len_out), 32'(MEM_LEN_H));
        e.dest = 4'd0; e.value = 32'hFFFF_9A5C;
        sb.push_back(e);
        rob_head_in = 4'd15;
        tick(); tick();
        memctrl_done_in = 1'b1; memctrl_data_in = 32'h0000_9A5C;
        addressUnit_en_in = 1'b1; addressUnit_addr_in = 32'h0000_810C;
        addressUnit_dest_in = 4'd4; addressUnit_inst_type_in = INST_LW;
        ld.addr = 32'h0000_810C; ld.dest = 4'd4; ld.typ = INST_LW;
        mq.push_back(ld);
        tick();
        memctrl_done_in = 1'b0; memctrl_data_in = '0; addressUnit_en_in = 1'b0;
        check("lh cdb_en", 32'(cdb_en_out), 32'd1);
        enq(INST_LW, 32'h0000_8110, 4'd5);
        check("rdy at count5 after swap", 32'(lsqueue_rdy_out), 32'd1);
        enq(INST_LW, 32'h0000_8114, 4'd6);
        check("rdy at count6 after swap", 32'(lsqueue_rdy_out), 32'd0);
        rob_store_pending_in = 1'b0;
        for (int i = 0; i < 6; i++)
            serve(32'h0000_C000 + 32'(i), 1, MEM_LEN_W, 32'h0000_C000 + 32'(i), $sformatf("swap%0d", i));
        tick(); tick();
        check("rdy at end", 32'(lsqueue_rdy_out), 32'd1);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: %0d results never broadcast, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
